// File: rtl/priority_arbiter8.sv
// priority_arbiter8 -- eight-requester arbiter for one shared downstream
// resource. A grant is held until its owner drops the request or, when
// MAX_HOLD is non-zero, until the owner has held it MAX_HOLD cycles.
// A requester revoked by the hold limit is skipped in the next
// arbitration that has another candidate.
//
// Compile-time option:
//   PRIORITY_ARBITER8_RR_EN  defined   -> round-robin search starting below
//                                         the last granted index
//                            undefined -> fixed priority, bit 7 highest
//
// Parameters:
//   MAX_HOLD     maximum consecutive grant cycles (0 = unlimited, 0..255)
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_i[7:0]   request vector, bit i held high while requester i wants/owns
//   gnt_o[7:0]   registered one-hot grant, zero when idle
//   gnt_id_o     registered binary index of the owner, zero when idle
//   gnt_valid_o  high while a grant is active (== |gnt_o)
//   timeout_o    one-cycle pulse in the first idle cycle after a revocation
//   dbg_state_o  FSM state: 0 = IDLE, 1 = GRANT
//
// Handshake: req_i[k] is a level request; the owner keeps it high for as
// long as it uses the resource and drops it to release. A release sampled
// at edge n clears the grant after edge n; the next grant can appear no
// earlier than after edge n+1.
module priority_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_id_o,
    output logic       gnt_valid_o,
    output logic       timeout_o,
    output logic       dbg_state_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       timeout_q, timeout_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [7:0] masked_req;
    logic [7:0] eligible;
    logic [2:0] winner;
    logic       owner_req;
    logic       limit_hit;

    // Highest set index wins.
    function automatic logic [2:0] pick_fixed(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifdef PRIORITY_ARBITER8_RR_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;

    // Search ptr-1, ptr-2, ... ptr (mod 8). The loop runs from the lowest
    // priority candidate (ptr itself) to the highest (ptr-1) so the last
    // eligible hit is the winner.
    function automatic logic [2:0] pick_rr(input logic [7:0] v, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            cand = ptr - 3'(i);
            if (v[cand]) idx = cand;
        end
        return idx;
    endfunction

    assign winner = pick_rr(eligible, rr_ptr_q);
`else
    assign winner = pick_fixed(eligible);
`endif

    // A masked requester is only excluded if someone else is asking.
    assign masked_req = req_i & ~mask_q;
    assign eligible   = (|masked_req) ? masked_req : req_i;
    assign owner_req  = req_i[gnt_id_q];
    assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q >= MAX_HOLD_L);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;
        mask_d     = mask_q;
        hold_cnt_d = hold_cnt_q;
`ifdef PRIORITY_ARBITER8_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d    = S_GRANT;
                    gnt_d      = 8'b1 << winner;
                    gnt_id_d   = winner;
                    hold_cnt_d = 8'd1;
                    mask_d     = 8'd0;
`ifdef PRIORITY_ARBITER8_RR_EN
                    rr_ptr_d   = winner;
`endif
                end
            end
            S_GRANT: begin
                // Release has precedence over the hold limit on the same edge.
                if (!owner_req) begin
                    state_d    = S_IDLE;
                    gnt_d      = 8'd0;
                    gnt_id_d   = 3'd0;
                    hold_cnt_d = 8'd0;
                end else if (limit_hit) begin
                    state_d    = S_IDLE;
                    gnt_d      = 8'd0;
                    gnt_id_d   = 3'd0;
                    hold_cnt_d = 8'd0;
                    timeout_d  = 1'b1;
                    mask_d     = gnt_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 8'd0;
            gnt_id_q   <= 3'd0;
            timeout_q  <= 1'b0;
            mask_q     <= 8'd0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef PRIORITY_ARBITER8_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 3'd0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = |gnt_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_priority_arbiter8.sv
module tb_priority_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_a, req_b;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] id_a, id_b;
    logic       valid_a, valid_b, to_a, to_b, st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Main instance: hold limit 4.
    priority_arbiter8 #(.MAX_HOLD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_a),
        .gnt_o(gnt_a), .gnt_id_o(id_a), .gnt_valid_o(valid_a),
        .timeout_o(to_a), .dbg_state_o(st_a)
    );

    // Second instance: hold limit 3.
    priority_arbiter8 #(.MAX_HOLD(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req_b),
        .gnt_o(gnt_b), .gnt_id_o(id_b), .gnt_valid_o(valid_b),
        .timeout_o(to_b), .dbg_state_o(st_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single arbitrations from a freshly reset arbiter.
    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } vec_t;

    vec_t vecs[8];

    int   n_valid;
    logic [2:0] exp_seq[9];

    initial begin
        rst_n = 1'b1;
        req_a = 8'h00;
        req_b = 8'h00;

        vecs[0] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[1] = '{8'h80, 8'h80, 3'd7, 1'b1};
        vecs[2] = '{8'h24, 8'h20, 3'd5, 1'b1};
        vecs[3] = '{8'hFF, 8'h80, 3'd7, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[5] = '{8'h0A, 8'h08, 3'd3, 1'b1};
        vecs[6] = '{8'h40, 8'h40, 3'd6, 1'b1};
        vecs[7] = '{8'h12, 8'h10, 3'd4, 1'b1};

        // Reset state
        do_reset();
        check("reset_gnt", 32'(gnt_a), 32'h0);
        check("reset_id", 32'(id_a), 32'h0);
        check("reset_valid", 32'(valid_a), 32'h0);
        check("reset_timeout", 32'(to_a), 32'h0);

        // Table-driven single arbitrations
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req_a = vecs[i].req;
            tick();
            check($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_id", i), 32'(id_a), 32'(vecs[i].id));
            check($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vecs[i].valid));
            req_a = 8'h00;
            tick();
            tick();
        end

        // Release, one dead cycle, next owner
        do_reset();
        req_a = 8'b0010_0100;
        tick();
        check("rel_first_id", 32'(id_a), 32'd5);
        req_a = 8'b0000_0100;
        tick();
        check("rel_cleared_valid", 32'(valid_a), 32'd0);
        check("rel_cleared_gnt", 32'(gnt_a), 32'd0);
        tick();
        check("rel_next_id", 32'(id_a), 32'd2);
        check("rel_next_valid", 32'(valid_a), 32'd1);
        req_a = 8'h00;
        tick();
        tick();

        // Hold limit: 4 valid cycles then a timeout pulse, masked requester skipped
        req_a = 8'h80;
        tick();
        n_valid = 0;
        for (int c = 0; c < 10 && valid_a; c++) begin
            n_valid++;
            check("hold_no_early_timeout", 32'(to_a), 32'd0);
            tick();
        end
        check("hold_valid_cycles", 32'(n_valid), 32'd4);
        check("hold_timeout_pulse", 32'(to_a), 32'd1);
        req_a = 8'h81;
        tick();
        check("mask_skip_id", 32'(id_a), 32'd0);
        check("mask_skip_valid", 32'(valid_a), 32'd1);
        check("timeout_one_cycle", 32'(to_a), 32'd0);
        req_a = 8'h00;
        tick();
        tick();

        // Hold limit with the masked bit as the only request
        req_a = 8'h80;
        for (int c = 0; c < 10 && !to_a; c++) tick();
        check("only_masked_timeout", 32'(to_a), 32'd1);
        check("only_masked_dead", 32'(valid_a), 32'd0);
        tick();
        check("only_masked_id", 32'(id_a), 32'd7);
        check("only_masked_valid", 32'(valid_a), 32'd1);
        req_a = 8'h00;
        tick();
        tick();

        // No preemption
        req_a = 8'h08;
        tick();
        check("nopre_first", 32'(id_a), 32'd3);
        req_a = 8'h88;
        tick();
        check("nopre_hold", 32'(id_a), 32'd3);
        req_a = 8'h80;
        tick();
        check("nopre_release", 32'(valid_a), 32'd0);
        tick();
        check("nopre_next", 32'(id_a), 32'd7);
        req_a = 8'h00;
        tick();
        tick();

        // Asynchronous reset mid-grant
        req_a = 8'h02;
        tick();
        check("arst_pre_id", 32'(id_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt_a), 32'd0);
        check("arst_id", 32'(id_a), 32'd0);
        check("arst_valid", 32'(valid_a), 32'd0);
        check("arst_timeout", 32'(to_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 8'h01;
        tick();
        check("arst_after_id", 32'(id_a), 32'd0);
        check("arst_after_valid", 32'(valid_a), 32'd1);
        req_a = 8'h00;
        tick();
        tick();

        // MAX_HOLD=3: timeout then mask takes effect
        req_b = 8'h10;
        tick();
        for (int c = 0; c < 10 && !to_b; c++) tick();
        check("h3_timeout", 32'(to_b), 32'd1);
        req_b = 8'h11;
        tick();
        check("h3_mask_id", 32'(id_b), 32'd0);
        req_b = 8'h00;
        tick();
        tick();

        // MAX_HOLD=3: release and expiry on the same edge
        req_b = 8'h10;
        tick();
        tick();
        tick();
        check("same_edge_still_owner", 32'(id_b), 32'd4);
        req_b = 8'h00;
        tick();
        check("same_edge_no_timeout", 32'(to_b), 32'd0);
        check("same_edge_released", 32'(valid_b), 32'd0);
        req_b = 8'h11;
        tick();
        check("same_edge_no_mask", 32'(id_b), 32'd4);
        req_b = 8'h00;
        tick();
        tick();

        // All requesting, each owner releasing after one cycle
`ifdef PRIORITY_ARBITER8_RR_EN
        exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        do_reset();
        req_a = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 5 && !valid_a; c++) tick();
            check($sformatf("seq%0d_valid", g), 32'(valid_a), 32'd1);
            check($sformatf("seq%0d_id", g), 32'(id_a), 32'(exp_seq[g]));
            req_a = ~gnt_a;
            tick();
            req_a = 8'hFF;
        end
        req_a = 8'h00;
        tick();
        tick();

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
